// File: rtl/dfa_table_loader.sv
// dfa_table_loader: writes one DFA state row (popcount(bitmap) transition entries) into the DFA RAM.
// Latency: cmd accept -> first ram_we in 2 cycles; 2 cycles per further entry (4 with read-back).
// Backpressure: cmd_ready only in IDLE, ent_ready only in ENTRY; the RAM port never stalls.
// Optional feature: define DFA_LOADER_READBACK_EN to read back and verify every written word.
module dfa_table_loader #(
  parameter logic [11:0] BASE_C2 = 12'h3B5,
  parameter logic [11:0] BASE_C3 = 12'h800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_class,
  input  logic [11:0] cmd_index,
  input  logic [15:0] cmd_bitmap,
  input  logic        ent_valid,
  output logic        ent_ready,
  input  logic [31:0] ent_data,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_rden,
  input  logic [31:0] ram_q,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FIN   = 3'd5;
`ifdef DFA_LOADER_READBACK_EN
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_CMP   = 3'd4;
`endif

  logic [2:0]  state;
  logic [11:0] row;       // row base address, fixed for the whole command
  logic [4:0]  k;         // entries written so far
  logic [4:0]  total;     // entries expected: popcount of the latched bitmap
  logic [31:0] entry;     // last accepted transition entry
  logic        fin_err;   // selects err vs done pulse in FIN

  logic [11:0] base_sel;
  logic [11:0] row_calc;
  logic [11:0] wr_addr;
  logic        last_entry;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  // Row address of the incoming command; only classes 0..3 are ever used, larger ones abort.
  always_comb begin
    case (cmd_class)
      4'd2:    base_sel = BASE_C2;
      4'd3:    base_sel = BASE_C3;
      default: base_sel = 12'h000;
    endcase
    row_calc = base_sel + cmd_index * {10'd0, cmd_class[1:0]};
  end

  assign wr_addr    = row + {8'd0, k[3:0]};
  assign last_entry = (k + 5'd1) == total;

  // Handshake and strobe outputs are decoded from state and held quiet while reset is high,
  // so a reset landing in WRITE or FIN cannot leak a write or a pulse.
  assign cmd_ready = (state == S_IDLE)  && !reset;
  assign ent_ready = (state == S_ENTRY) && !reset;
  assign ram_we    = (state == S_WRITE) && !reset;
  assign load_done = (state == S_FIN) && !fin_err && !reset;
  assign load_err  = (state == S_FIN) &&  fin_err && !reset;
  assign ram_addr  = (ram_we || ram_rden) ? wr_addr : 12'h000;
  assign ram_din   = ram_we ? entry : 32'h0;

`ifdef DFA_LOADER_READBACK_EN
  assign ram_rden = (state == S_RD) && !reset;
`else
  logic unused_ram_q;
  assign ram_rden     = 1'b0;
  assign unused_ram_q = ^ram_q;
`endif

  // Load sequencer: latch command, collect entries one by one, write, optionally verify.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      k       <= 5'd0;
      total   <= 5'd0;
      row     <= 12'h000;
      entry   <= 32'h0;
      fin_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            row   <= row_calc;
            k     <= 5'd0;
            total <= popcount16(cmd_bitmap);
            if (cmd_class > 4'd3) begin
              fin_err <= 1'b1;
              state   <= S_FIN;
            end else if (cmd_bitmap == 16'h0000) begin
              fin_err <= 1'b0;
              state   <= S_FIN;
            end else begin
              fin_err <= 1'b0;
              state   <= S_ENTRY;
            end
          end
        end
        S_ENTRY: begin
          if (ent_valid) begin
            entry <= ent_data;
            if (ent_data[31:28] > 4'd3) begin
              fin_err <= 1'b1;
              state   <= S_FIN;
            end else begin
              state <= S_WRITE;
            end
          end
        end
`ifdef DFA_LOADER_READBACK_EN
        S_WRITE: state <= S_RD;
        S_RD:    state <= S_CMP;
        S_CMP: begin
          if (ram_q != entry) begin
            fin_err <= 1'b1;
            state   <= S_FIN;
          end else begin
            k     <= k + 5'd1;
            state <= last_entry ? S_FIN : S_ENTRY;
          end
        end
`else
        S_WRITE: begin
          k     <= k + 5'd1;
          state <= last_entry ? S_FIN : S_ENTRY;
        end
`endif
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dfa_table_loader.md
DFA_TABLE_LOADER -- requirements
Module: dfa_table_loader

Interface
REQ-001 The block SHALL have parameter BASE_C2, default 12'h3B5, giving the base address of class-2 states.
REQ-002 The block SHALL have parameter BASE_C3, default 12'h800, giving the base address of class-3 states.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_class (in, 4), cmd_index (in, 12) and cmd_bitmap (in, 16): the state descriptor handshake.
REQ-006 The block SHALL have ports ent_valid (in, 1), ent_ready (out, 1) and ent_data (in, 32): the transition-entry stream, laid out as {class[31:28], next_index[27:16], valid_bitmap[15:0]}.
REQ-007 The block SHALL have ports ram_we (out, 1), ram_addr (out, 12) and ram_din (out, 32): the DFA RAM write port.
REQ-008 The block SHALL have ports ram_rden (out, 1) and ram_q (in, 32): the RAM read-back port, with 1-cycle read latency.
REQ-009 The block SHALL have ports load_done (out, 1), a one-cycle pulse marking command completion, and load_err (out, 1), a one-cycle pulse marking command abort.

Function
REQ-010 The state machine SHALL have states IDLE, ENTRY, WRITE, RD, CMP and FIN.
REQ-011 In IDLE, cmd_ready=1; on cmd_valid&&cmd_ready the block SHALL latch class, index and bitmap, and clear k to 0.
REQ-012 A latched class greater than 3 SHALL go to FIN with load_err=1, and no RAM write SHALL occur.
REQ-013 A latched bitmap of 16'h0000 SHALL go to FIN with load_done=1, and no RAM write SHALL occur.
REQ-014 Base address SHALL be 0 for class 0 and class 1, BASE_C2 for class 2, and BASE_C3 for class 3; the row address SHALL be base + index*class, computed once at latch and truncated to 12 bits (wrap-around intended).
REQ-015 In ENTRY, ent_ready=1; on ent_valid the block SHALL register ent_data and go to WRITE.
REQ-016 An accepted ent_data[31:28] greater than 3 SHALL abort to FIN with load_err=1.
REQ-017 WRITE SHALL assert ram_we for exactly one cycle, with ram_addr = row + k (12-bit wrap) and ram_din = the registered entry.
REQ-018 After each write, k SHALL increment, and the number of accepted entries SHALL equal popcount(bitmap) (1..16); after the last entry the block SHALL go to FIN with load_done=1, otherwise it SHALL return to ENTRY.
REQ-019 cmd_ready SHALL be 0 outside IDLE, and ent_ready SHALL be 0 outside ENTRY; a new command SHALL never be accepted mid-load.
REQ-020 ram_we, ram_rden, load_done and load_err SHALL never be asserted simultaneously with each other.
REQ-021 FIN SHALL last one cycle, then go to IDLE; minimum latency is cmd accept -> first ram_we in 2 cycles (ENTRY accept cycle + WRITE).

Reset
REQ-022 Reset SHALL force IDLE and k=0, and SHALL drive cmd_ready=1 from the following cycle.
REQ-023 Reset SHALL drive ent_ready=0, ram_we=0, ram_rden=0, ram_addr=0, ram_din=0, load_done=0 and load_err=0.
REQ-024 Reset asserted mid-load SHALL discard the command with no further write and no done or err pulse; RAM contents already written SHALL remain.

Configuration
REQ-025 With macro DFA_LOADER_READBACK_EN defined, WRITE SHALL be followed by RD (ram_rden=1, same address) and then CMP.
REQ-026 In CMP, if ram_q is not equal to the written word, the block SHALL abort to FIN with load_err=1; otherwise it SHALL continue per REQ-018.
REQ-027 Without DFA_LOADER_READBACK_EN, the RD and CMP states SHALL be absent, ram_rden SHALL be tied 0, ram_q SHALL be ignored, and WRITE SHALL proceed directly per REQ-018.

Verification
REQ-028 A bench SHALL cover: cmd class=2, index=3, bitmap=16'h0005, entries 32'h1000_0003 and 32'h2001_0001 -> writes to 12'h3BB then 12'h3BC, then a load_done pulse.
REQ-029 A bench SHALL cover: cmd class=3, index=12'hFFF, bitmap=16'h8000 -> single write at 12'h7FD (wrap), then load_done.
REQ-030 A bench SHALL cover: cmd class=5 -> load_err pulse, zero ram_we, and cmd_ready=1 two cycles later.
REQ-031 A bench SHALL cover: bitmap=16'hFFFF, class=1, index=0, with ent_valid toggled randomly -> exactly 16 writes at addresses 0..15, in order, then load_done.
REQ-032 A bench SHALL cover: reset asserted after the 2nd of 4 entries -> no further ram_we, no done/err pulse, IDLE with cmd_ready=1.
REQ-033 A bench SHALL cover: with DFA_LOADER_READBACK_EN defined and the RAM model corrupting bit 0 on read -> load_err after the first write, with no second write.
